// File: rtl/mpt_pkg.sv
// Shared MPT types and machine widths for the page-table walker and its memory responder.
package mpt_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned PLEN = 56;

    typedef struct packed {
        logic            valid;
        logic            err;
        logic [XLEN-1:0] rdata;
    } mpt_mem_rsp_t;

endpackage

// File: rtl/mpt_rsp_pipe.sv
// Fixed-latency response delay line: RESP_LATENCY stages of mpt_mem_rsp_t.
module mpt_rsp_pipe
    import mpt_pkg::*;
#(
    parameter int unsigned RESP_LATENCY = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  mpt_mem_rsp_t rsp_i,
    output mpt_mem_rsp_t rsp_o
);

    mpt_mem_rsp_t stage [RESP_LATENCY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RESP_LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= rsp_i;
            for (int unsigned i = 1; i < RESP_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign rsp_o = stage[RESP_LATENCY-1];

endmodule

// File: rtl/mpt_mem_responder.sv
// Table memory model answering walker requests with fixed latency, fault
// detection on misaligned/out-of-range addresses and bounded outstanding responses.
module mpt_mem_responder
    import mpt_pkg::*;
#(
    parameter int unsigned DEPTH           = 256,
    parameter int unsigned RESP_LATENCY    = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [PLEN-1:0]   addr_i,
    input  logic              we_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN/8-1:0] be_i,
    input  logic              stall_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              err_o
);

    localparam int unsigned BW = XLEN / 8;
    localparam int unsigned OW = $clog2(BW);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [XLEN-1:0] mem [DEPTH];
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic            misaligned;
    logic            out_of_range;
    logic            fault;
    logic            accept;
    logic            retire;
    mpt_mem_rsp_t    rsp_in;
    mpt_mem_rsp_t    rsp_out;

    assign idx          = addr_i[IW+OW-1:OW];
    assign misaligned   = |addr_i[OW-1:0];
    assign out_of_range = |(addr_i >> (IW + OW));
    assign fault        = misaligned | out_of_range;

    // A retiring response frees its slot in the same cycle, so a full counter can still grant.
    assign retire = rsp_out.valid;
    assign gnt_o  = req_i & ~stall_i & ((cnt < MAX_CNT) | retire);
    assign accept = req_i & gnt_o;

    always_comb begin
        rsp_in = '0;
        if (accept) begin
            rsp_in.valid = 1'b1;
            rsp_in.err   = fault;
            if (!fault && !we_i) begin
                rsp_in.rdata = mem[idx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && we_i && !fault) begin
            for (int unsigned b = 0; b < BW; b++) begin
                if (be_i[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    mpt_rsp_pipe #(
        .RESP_LATENCY(RESP_LATENCY)
    ) u_rsp_pipe (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .rsp_i (rsp_in),
        .rsp_o (rsp_out)
    );

    assign rvalid_o = rsp_out.valid;
    assign rdata_o  = rsp_out.valid ? rsp_out.rdata : '0;
    assign err_o    = rsp_out.valid & rsp_out.err;

endmodule

// File: tb/tb_mpt_mem_responder.sv
// Directed bench for mpt_mem_responder: default instance plus a MAX_OUTSTANDING=1 instance on shared inputs.
module tb_mpt_mem_responder;
    import mpt_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            req;
    logic [PLEN-1:0] addr;
    logic            we;
    logic [XLEN-1:0] wdata;
    logic [7:0]      be;
    logic            stall;

    logic            gnt, rvalid, err;
    logic [XLEN-1:0] rdata;
    logic            gnt2, rvalid2, err2;
    logic [XLEN-1:0] rdata2;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    mpt_mem_responder u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we),
        .wdata_i(wdata), .be_i(be), .stall_i(stall),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
    );

    mpt_mem_responder #(.MAX_OUTSTANDING(1)) u_dut_mo1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we),
        .wdata_i(wdata), .be_i(be), .stall_i(stall),
        .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2), .err_o(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single isolated access: grant in the issue cycle, response exactly two cycles later.
    task automatic access(input string tag, input logic w, input logic [PLEN-1:0] a,
                          input logic [XLEN-1:0] d, input logic [7:0] b,
                          input logic [XLEN-1:0] exp_d, input logic exp_e);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(negedge clk);
        chk({tag, ".gnt"}, gnt, 1);
        tick();
        req = 1'b0; we = 1'b0; wdata = '0; be = '0;
        @(negedge clk);
        chk({tag, ".rv_early"}, rvalid, 0);
        tick();
        @(negedge clk);
        chk({tag, ".rvalid"}, rvalid, 1);
        chk({tag, ".rdata"}, rdata, exp_d);
        chk({tag, ".err"}, err, exp_e);
        tick();
        @(negedge clk);
        chk({tag, ".rv_once"}, rvalid, 0);
        tick();
    endtask

    // Reads of 0x8 under per-cycle req/stall masks, checked against per-cycle expectation masks.
    task automatic stream(input string tag, input logic [15:0] req_m, input logic [15:0] stall_m,
                          input logic [15:0] gnt_m, input logic [15:0] rv_m,
                          input logic [15:0] gnt2_m, input logic [15:0] rv2_m, input bit chk2);
        for (int i = 0; i < 10; i++) begin
            req = req_m[i]; stall = stall_m[i]; we = 1'b0; addr = 'h8;
            @(negedge clk);
            chk($sformatf("%s.gnt[%0d]", tag, i), gnt, gnt_m[i]);
            chk($sformatf("%s.rv[%0d]", tag, i), rvalid, rv_m[i]);
            chk($sformatf("%s.rdata[%0d]", tag, i), rdata, {63'b0, rv_m[i]});
            if (chk2) begin
                chk($sformatf("%s.gnt_mo1[%0d]", tag, i), gnt2, gnt2_m[i]);
                chk($sformatf("%s.rv_mo1[%0d]", tag, i), rvalid2, rv2_m[i]);
            end
            tick();
        end
        req = 1'b0; stall = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.rvalid", rvalid, 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.err", err, 0);
        chk("rst.gnt", gnt, 0);
        tick();
        rst_n = 1'b1;

        // first edge after reset release accepts
        access("wr8",      1'b1, 'h8,   64'h1,          8'hFF, 64'h0, 1'b0);
        access("rd8",      1'b0, 'h8,   64'h0,          8'h00, 64'h1, 1'b0);
        access("wr10a",    1'b1, 'h10,  {64{1'b1}},     8'hFF, 64'h0, 1'b0);
        access("wr10b",    1'b1, 'h10,  64'h0,          8'h0F, 64'h0, 1'b0);
        access("rd10",     1'b0, 'h10,  64'h0,          8'h00, 64'hFFFF_FFFF_0000_0000, 1'b0);
        access("rd800",    1'b0, 'h800, 64'h0,          8'h00, 64'h0, 1'b1);
        access("rd4",      1'b0, 'h4,   64'h0,          8'h00, 64'h0, 1'b1);
        access("wr4",      1'b1, 'h4,   64'hDEAD_BEEF,  8'hFF, 64'h0, 1'b1);
        access("wr800",    1'b1, 'h800, 64'hDEAD_BEEF,  8'hFF, 64'h0, 1'b1);
        access("rd0",      1'b0, 'h0,   64'h0,          8'h00, 64'h0, 1'b0);
        access("wr7f8",    1'b1, 'h7F8, 64'h55,         8'hFF, 64'h0, 1'b0);
        access("rd7f8",    1'b0, 'h7F8, 64'h0,          8'h00, 64'h55, 1'b0);

        // write-like inputs without req must not touch the array
        req = 1'b0; we = 1'b1; addr = 'h8; wdata = 64'hBAD; be = 8'hFF;
        tick();
        access("rd8_idle", 1'b0, 'h8,   64'h0,          8'h00, 64'h1, 1'b0);

        // write then read of the same word on consecutive cycles
        req = 1'b1; we = 1'b1; addr = 'h18; wdata = 64'hA5; be = 8'hFF;
        @(negedge clk);
        chk("b2b.gnt_wr", gnt, 1);
        tick();
        we = 1'b0; wdata = '0; be = '0;
        @(negedge clk);
        chk("b2b.gnt_rd", gnt, 1);
        tick();
        req = 1'b0;
        @(negedge clk);
        chk("b2b.rv_wr", rvalid, 1);
        chk("b2b.rdata_wr", rdata, 0);
        tick();
        @(negedge clk);
        chk("b2b.rv_rd", rvalid, 1);
        chk("b2b.rdata_rd", rdata, 64'hA5);
        tick();
        @(negedge clk);
        chk("b2b.rv_end", rvalid, 0);
        repeat (3) tick();

        stream("cont",  16'h003F, 16'h0000, 16'h003F, 16'h00FC, 16'h0015, 16'h0054, 1'b1);
        stream("stall", 16'h003F, 16'h000E, 16'h0031, 16'h00C4, 16'h0000, 16'h0000, 1'b0);

        // reset with two reads in flight
        req = 1'b1; we = 1'b0; addr = 'h8;
        @(negedge clk);
        chk("rst2.gnt0", gnt, 1);
        tick();
        @(negedge clk);
        chk("rst2.gnt1", gnt, 1);
        tick();
        req = 1'b0;
        chk("rst2.rv_pre", rvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst2.rv_now", rvalid, 0);
        chk("rst2.rdata_now", rdata, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rst2.rv_after[%0d]", i), rvalid, 0);
            chk($sformatf("rst2.rv_mo1_after[%0d]", i), rvalid2, 0);
            tick();
        end
        access("rd8_rst", 1'b0, 'h8, 64'h0, 8'h00, 64'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mpt_mem_responder.md
MPT_MEM_RESPONDER -- requirements
Module: mpt_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of XLEN-bit table words held; power of two, at least 2.
REQ-002 SHALL have parameter RESP_LATENCY, default 2: cycles from grant to rvalid; at least 1.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2: maximum in-flight responses; range 1..RESP_LATENCY.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_i, input, 1: walker request valid.
REQ-007 SHALL have port addr_i, input, PLEN: byte address.
REQ-008 SHALL have port we_i, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port wdata_i, input, XLEN: write data.
REQ-010 SHALL have port be_i, input, XLEN/8: byte enables, writes only.
REQ-011 SHALL have port stall_i, input, 1: backpressure injection; suppresses grant.
REQ-012 SHALL have port gnt_o, output, 1: request accepted this cycle.
REQ-013 SHALL have port rvalid_o, output, 1: response valid.
REQ-014 SHALL have port rdata_o, output, XLEN: read data.
REQ-015 SHALL have port err_o, output, 1: access fault, qualified by rvalid_o.

Function
REQ-016 SHALL drive gnt_o combinationally as: req_i AND NOT stall_i AND (outstanding < MAX_OUTSTANDING OR a response retires this cycle).
REQ-017 SHALL treat a request as accepted in a cycle exactly when req_i and gnt_o are both 1.
REQ-018 SHALL form the word index as addr_i[log2(DEPTH)+log2(XLEN/8)-1 : log2(XLEN/8)].
REQ-019 SHALL fault an accepted access if addr_i[log2(XLEN/8)-1:0] is nonzero (misaligned).
REQ-020 SHALL fault an accepted access if addr_i >= DEPTH*XLEN/8 (out of range).
REQ-021 SHALL, on a faulting access, leave the array unmodified and return err_o=1 with rdata_o=0.
REQ-022 SHALL, on an accepted non-faulting write, update only the bytes whose be_i bit is 1, at the accept edge.
REQ-023 SHALL return rdata_o=0 for every write response.
REQ-024 SHALL sample read data at the accept edge, so a read accepted the cycle after a write to the same word returns the new data.
REQ-025 SHALL assert rvalid_o for exactly one cycle per accepted request, exactly RESP_LATENCY cycles after its accept cycle.
REQ-026 SHALL deliver responses in acceptance order, with no back-to-back gaps imposed.
REQ-027 SHALL drive rdata_o=0 and err_o=0 whenever rvalid_o=0.
REQ-028 SHALL keep an outstanding counter of width clog2(MAX_OUTSTANDING+1): +1 on accept, -1 on retire, unchanged when both occur in the same cycle; it never exceeds MAX_OUTSTANDING.
REQ-029 SHALL never accept while the counter is full unless a retire occurs in that same cycle.
REQ-030 SHALL never drop or duplicate responses while stall_i toggles; stall_i gates grant only.
REQ-031 SHALL ignore addr_i, we_i, wdata_i and be_i when no request is accepted.

Reset
REQ-032 SHALL, while rst_ni=0, immediately force gnt_o-qualifying state, rvalid_o, rdata_o and err_o to 0, clear the counter and delay line, and zero the array.
REQ-033 SHALL discard requests that were in flight when reset asserted, with no response after rst_ni releases.
REQ-034 SHALL accept a request on the first rising edge with rst_ni=1.

Structure
REQ-035 SHALL add to mpt_pkg a packed struct mpt_mem_rsp_t {valid, err, rdata[XLEN]} for use by responder and walker.
REQ-036 SHALL take XLEN and PLEN from mpt_pkg and define no local copies.
REQ-037 SHALL implement the fixed-latency delay line as one sub-module mpt_rsp_pipe: a RESP_LATENCY-stage shift register of mpt_mem_rsp_t.
REQ-038 SHALL keep the array, index and fault decode, and counter in the top module.

Verification (rv64, defaults unless noted)
REQ-039 SHALL cover: write 0x8, wdata 0x1, be 0xFF, then read 0x8 -> read rvalid 2 cycles after its grant, rdata 0x1, err 0.
REQ-040 SHALL cover: write 0x10 with 0xFFFF_FFFF_FFFF_FFFF, then write 0x10 with 0, be 0x0F, then read -> rdata 0xFFFF_FFFF_0000_0000.
REQ-041 SHALL cover: read 0x800 and read 0x4 -> each err=1, rdata 0, rvalid at +2; array unchanged.
REQ-042 SHALL cover: req_i held high for 6 cycles with MAX_OUTSTANDING=1 -> gnt on cycles 0, 2, 4, rvalid on 2, 4, 6; with default 2 -> gnt every cycle.
REQ-043 SHALL cover: stall_i=1 for cycles 1..3 under continuous req_i -> no gnt in cycles 1..3; earlier responses still arrive on time.
REQ-044 SHALL cover: rst_ni low for 1 cycle with 2 reads outstanding -> rvalid_o 0 immediately, no responses afterwards, read of 0x8 returns 0.
